// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter: serves instruction fetches and data loads/stores with store lane
// steering and load extension. Define MEM_ARB_MISALIGN_TRAP_EN to trap misaligned data accesses.
module mem_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  instr_fetch_en_i,
    input  logic [31:0]           instr_addr_i,
    output logic [DATA_WIDTH-1:0] imem_data_o,
    output logic                  imem_ready_o,
    input  logic                  dmem_rd_en_i,
    input  logic                  dmem_wr_en_i,
    input  logic [31:0]           dmem_addr_i,
    input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
    input  logic [2:0]            ls_data_extend_i,
    output logic [DATA_WIDTH-1:0] dmem_rdata_o,
    output logic                  dmem_ready_o,
    output logic                  misalign_err_o,
    output logic                  sram_cs_o,
    output logic                  sram_we_o,
    output logic [3:0]            sram_be_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                r_state;
    logic                  r_fetch_pend;
    logic                  r_is_fetch;
    logic                  r_is_wr;
    logic                  r_skip;
    logic [2:0]            r_f3;
    logic [1:0]            r_lane;
    logic [3:0]            r_cnt;
    logic                  r_cs;
    logic                  r_we;
    logic [3:0]            r_be;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_imem_data;
    logic [DATA_WIDTH-1:0] r_dmem_rdata;
    logic                  r_imem_ready;
    logic                  r_dmem_ready;
    logic                  r_err;

    logic                  w_data_req;
    logic                  w_fetch_req;
    logic                  w_grant_data;
    logic                  w_grant_fetch;
    logic                  w_misalign;
    logic [3:0]            w_st_be;
    logic [DATA_WIDTH-1:0] w_st_wdata;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_ld_data;
    logic                  w_unused;

    assign w_data_req    = dmem_rd_en_i | dmem_wr_en_i;
    // A fetch pulse in IDLE is granted in the same cycle, without waiting for fetch_pend.
    assign w_fetch_req   = r_fetch_pend | instr_fetch_en_i;
    assign w_grant_data  = (r_state == S_IDLE) & w_data_req;
    assign w_grant_fetch = (r_state == S_IDLE) & ~w_data_req & w_fetch_req;

`ifdef MEM_ARB_MISALIGN_TRAP_EN
    assign w_misalign = ((ls_data_extend_i[1:0] == 2'b01) & dmem_addr_i[0]) |
                        (ls_data_extend_i[1] & (dmem_addr_i[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_unused = ^{instr_addr_i[31:ADDR_WIDTH+2], instr_addr_i[1:0],
                        dmem_addr_i[31:ADDR_WIDTH+2]};

    always_comb begin
        w_st_be    = 4'b1111;
        w_st_wdata = dmem_wdata_i;
        case (ls_data_extend_i[1:0])
            2'b00: begin
                w_st_be    = 4'b0001 << dmem_addr_i[1:0];
                w_st_wdata = {4{dmem_wdata_i[7:0]}};
            end
            2'b01: begin
                w_st_be    = 4'b0011 << {dmem_addr_i[1], 1'b0};
                w_st_wdata = {2{dmem_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = sram_rdata_i[7:0];
        case (r_lane)
            2'd1:    w_byte = sram_rdata_i[15:8];
            2'd2:    w_byte = sram_rdata_i[23:16];
            2'd3:    w_byte = sram_rdata_i[31:24];
            default: ;
        endcase
        w_half = r_lane[1] ? sram_rdata_i[31:16] : sram_rdata_i[15:0];
        if (r_f3[1])
            w_ld_data = sram_rdata_i;
        else if (r_f3[0])
            w_ld_data = r_f3[2] ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
        else
            w_ld_data = r_f3[2] ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state      <= S_IDLE;
            r_fetch_pend <= 1'b0;
            r_is_fetch   <= 1'b0;
            r_is_wr      <= 1'b0;
            r_skip       <= 1'b0;
            r_f3         <= '0;
            r_lane       <= '0;
            r_cnt        <= '0;
            r_cs         <= 1'b0;
            r_we         <= 1'b0;
            r_be         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_imem_data  <= '0;
            r_dmem_rdata <= '0;
            r_imem_ready <= 1'b0;
            r_dmem_ready <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_imem_ready <= 1'b0;
            r_dmem_ready <= 1'b0;

            // Granting from fetch_pend keeps it set only if a fresh pulse lands in the same cycle.
            if (w_grant_fetch)
                r_fetch_pend <= r_fetch_pend & instr_fetch_en_i;
            else if (instr_fetch_en_i)
                r_fetch_pend <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_grant_data) begin
                        r_state    <= S_ACC;
                        r_is_fetch <= 1'b0;
                        r_is_wr    <= dmem_wr_en_i;
                        r_skip     <= w_misalign;
                        r_f3       <= ls_data_extend_i;
                        r_lane     <= dmem_addr_i[1:0];
                        r_cs       <= ~w_misalign;
                        r_we       <= dmem_wr_en_i & ~w_misalign;
                        r_be       <= dmem_wr_en_i ? w_st_be : 4'b1111;
                        r_addr     <= dmem_addr_i[ADDR_WIDTH+1:2];
                        r_wdata    <= w_st_wdata;
                        if (w_misalign)
                            r_err <= 1'b1;
                    end else if (w_grant_fetch) begin
                        r_state    <= S_ACC;
                        r_is_fetch <= 1'b1;
                        r_is_wr    <= 1'b0;
                        r_skip     <= 1'b0;
                        r_cs       <= 1'b1;
                        r_we       <= 1'b0;
                        r_be       <= 4'b1111;
                        r_addr     <= instr_addr_i[ADDR_WIDTH+1:2];
                    end
                end
                S_ACC: begin
                    r_cs    <= 1'b0;
                    r_we    <= 1'b0;
                    r_cnt   <= 4'(WAIT_STATES);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                        if (r_is_fetch) begin
                            r_imem_data  <= sram_rdata_i;
                            r_imem_ready <= 1'b1;
                        end else begin
                            if (r_skip)
                                r_dmem_rdata <= '0;
                            else if (!r_is_wr)
                                r_dmem_rdata <= w_ld_data;
                            r_dmem_ready <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_data_o    = r_imem_data;
    assign imem_ready_o   = r_imem_ready;
    assign dmem_rdata_o   = r_dmem_rdata;
    assign dmem_ready_o   = r_dmem_ready;
    assign misalign_err_o = r_err;
    assign sram_cs_o      = r_cs;
    assign sram_we_o      = r_we;
    assign sram_be_o      = r_be;
    assign sram_addr_o    = r_addr;
    assign sram_wdata_o   = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter with a transaction-level memory model.
// Honours MEM_ARB_MISALIGN_TRAP_EN the same way the design does.
module tb_mem_arbiter;

    localparam int AW = 12;
    localparam int WS = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [2:0]  f3_in = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mis_err;
    logic        cs, we;
    logic [3:0]  be;
    logic [AW-1:0] s_addr;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;

    logic        bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [31:0] bd_data = '0;

    logic [31:0] sram    [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];
    logic [31:0] exp_imem = '0;
    logic [31:0] exp_dmem = '0;
    logic        exp_err  = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .clk_i(clk), .reset_i(rst_n),
        .instr_fetch_en_i(fetch_en), .instr_addr_i(fetch_addr),
        .imem_data_o(imem_data), .imem_ready_o(imem_ready),
        .dmem_rd_en_i(rd_en), .dmem_wr_en_i(wr_en), .dmem_addr_i(d_addr),
        .dmem_wdata_i(d_wdata), .ls_data_extend_i(f3_in),
        .dmem_rdata_o(d_rdata), .dmem_ready_o(d_ready), .misalign_err_o(mis_err),
        .sram_cs_o(cs), .sram_we_o(we), .sram_be_o(be), .sram_addr_o(s_addr),
        .sram_wdata_o(s_wdata), .sram_rdata_i(s_rdata)
    );

    // SRAM model with a backdoor preload port
    always @(posedge clk) begin
        if (bd_we) begin
            sram[bd_addr] <= bd_data;
        end else if (cs) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) sram[s_addr][8*b +: 8] <= s_wdata[8*b +: 8];
            end else begin
                s_rdata <= sram[s_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input int w, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = AW'(w); bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[w] = d;
    endtask

    function automatic logic [31:0] ld_ext(input logic [31:0] word, input logic [1:0] lo,
                                           input logic [2:0] f3);
        logic [31:0] s;
        if (f3[1]) return word;
        if (!f3[0]) begin
            s = word >> (8 * lo);
            return f3[2] ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
        end
        s = word >> (16 * lo[1]);
        return f3[2] ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
    endfunction

    // kind: 0 fetch, 1 load, 2 store. Called on a negedge in IDLE; that negedge is cycle 0.
    task automatic run_op(input int kind, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] wd, input bit plus_fetch, input logic [31:0] fa);
        logic [AW-1:0] w;
        logic [3:0]    be_e;
        logic [31:0]   wd_e;
        bit            mis;
        int            n_cs, n_i, n_d, t_i, t_d, last;
        w = a[AW+1:2];
        mis = 1'b0;
`ifdef MEM_ARB_MISALIGN_TRAP_EN
        if (kind != 0) mis = ((f3[1:0] == 2'b01) && a[0]) || (f3[1] && (a[1:0] != 2'b00));
`endif
        be_e = 4'b1111;
        wd_e = wd;
        if (kind == 2 && f3[1:0] == 2'b00) begin be_e = 4'b0001 << a[1:0]; wd_e = {4{wd[7:0]}}; end
        if (kind == 2 && f3[1:0] == 2'b01) begin be_e = 4'b0011 << (2 * a[1]); wd_e = {2{wd[15:0]}}; end

        if (kind == 0) begin
            fetch_en = 1'b1; fetch_addr = a;
        end else begin
            rd_en = (kind == 1); wr_en = (kind == 2);
            d_addr = a; f3_in = f3; d_wdata = wd;
            if (plus_fetch) begin fetch_en = 1'b1; fetch_addr = fa; end
        end

        n_cs = 0; n_i = 0; n_d = 0; t_i = 0; t_d = 0;
        last = plus_fetch ? 8 + 2*WS : 4 + WS;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1) begin
                fetch_en = 1'b0;
                check("acc_cs", 32'(cs), 32'(!mis));
                if (!mis) begin
                    check("acc_addr", 32'(s_addr), 32'(w));
                    check("acc_we", 32'(we), 32'(kind == 2));
                    if (kind != 1) check("acc_be", 32'(be), 32'(be_e));
                    if (kind == 2) check("acc_wdata", s_wdata, wd_e);
                end
            end
            if (cs) n_cs++;
            if (imem_ready) begin n_i++; if (t_i == 0) t_i = c; end
            if (d_ready) begin
                n_d++; if (t_d == 0) t_d = c;
                rd_en = 1'b0; wr_en = 1'b0;
            end
        end
        rd_en = 1'b0; wr_en = 1'b0;

        if (mis) exp_err = 1'b1;
        case (kind)
            0: exp_imem = ref_mem[w];
            1: exp_dmem = mis ? 32'h0 : ld_ext(ref_mem[w], a[1:0], f3);
            default: begin
                if (mis) exp_dmem = 32'h0;
                else for (int b = 0; b < 4; b++)
                    if (be_e[b]) ref_mem[w][8*b +: 8] = wd_e[8*b +: 8];
            end
        endcase
        if (plus_fetch) exp_imem = ref_mem[fa[AW+1:2]];

        if (kind == 0) begin
            check("fetch_lat", 32'(t_i), 32'(3 + WS));
        end else begin
            check("data_lat", 32'(t_d), 32'(3 + WS));
            if (plus_fetch) check("fetch_after_data_lat", 32'(t_i), 32'(7 + 2*WS));
        end
        check("imem_data", imem_data, exp_imem);
        check("dmem_rdata", d_rdata, exp_dmem);
        check("imem_strobes", 32'(n_i), 32'(kind == 0 || plus_fetch));
        check("dmem_strobes", 32'(n_d), 32'(kind != 0));
        check("cs_cycles", 32'(n_cs), 32'(!mis) + 32'(plus_fetch));
        check("misalign_err", 32'(mis_err), 32'(exp_err));
    endtask

    initial begin
        int k, ns;
        logic [2:0] f3r;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {26'h0, cs, we, be}, 32'h0);
        check("rst_strobe", {29'h0, imem_ready, d_ready, mis_err}, 32'h0);
        check("rst_data", imem_data | d_rdata | s_wdata | 32'(s_addr), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 64; i++) poke(i, $urandom);
        poke(4, 32'h0000_0513);
        poke(8, 32'h1234_80FF);

        run_op(0, 32'h10, 3'b000, 32'h0, 1'b0, 32'h0);
        check("dir_fetch", imem_data, 32'h0000_0513);
        run_op(1, 32'h21, 3'b000, 32'h0, 1'b0, 32'h0);
        check("dir_lb", d_rdata, 32'hFFFF_FF80);
        run_op(1, 32'h21, 3'b100, 32'h0, 1'b0, 32'h0);
        check("dir_lbu", d_rdata, 32'h0000_0080);
        run_op(2, 32'h42, 3'b001, 32'h0000_BEEF, 1'b0, 32'h0);
        run_op(1, 32'h40, 3'b010, 32'h0, 1'b0, 32'h0);
        check("dir_lw_hi", {16'h0, d_rdata[31:16]}, 32'h0000_BEEF);
        run_op(1, 32'h24, 3'b010, 32'h0, 1'b1, 32'h10);
`ifdef MEM_ARB_MISALIGN_TRAP_EN
        run_op(1, 32'h03, 3'b010, 32'h0, 1'b0, 32'h0);
        check("dir_mis_err", 32'(mis_err), 32'h1);
`endif

        // Reset in the middle of a load: everything clears and no strobe follows
        rd_en = 1'b1; d_addr = 32'h24; f3_in = 3'b010;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {26'h0, cs, we, be}, 32'h0);
        check("midrst_strobe", {29'h0, imem_ready, d_ready, mis_err}, 32'h0);
        check("midrst_data", imem_data | d_rdata | s_wdata | 32'(s_addr), 32'h0);
        rd_en = 1'b0;
        ns = 0;
        repeat (2) begin @(negedge clk); if (imem_ready || d_ready) ns++; end
        rst_n = 1'b1;
        repeat (WS + 5) begin @(negedge clk); if (imem_ready || d_ready) ns++; end
        check("midrst_no_strobe", 32'(ns), 32'h0);
        exp_imem = '0; exp_dmem = '0; exp_err = 1'b0;

        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 2);
            if (k == 2) f3r = {1'b0, 2'($urandom_range(0, 2))};
            else        f3r = 3'($urandom_range(0, 7));
            run_op(k, 32'($urandom_range(0, 255)), f3r, $urandom,
                   (k != 0) && ($urandom_range(0, 3) == 0), 32'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
